pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline: drives the per-stage hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves the following hazards in a fixed priority order: exception/eret redirect, data-SRAM wait, multi-cycle divide, load-use, and instruction-SRAM wait. An FSM sequences the divide stall and the discard of a stale in-flight fetch after a redirect. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage hold/bubble controls,
// divide and post-redirect fetch-drop FSM, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
   parameter int unsigned DIV_CYCLES = 32,
   parameter int unsigned CNT_W      = 6
) (
   input  logic        clk,
   input  logic        rset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_regW,
   input  logic        div_start,
   input  logic        mem_wait,
   input  logic        inst_wait,
   input  logic        exc_valid,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        mem_wb_flush,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {StRun, StDiv, StDrop} state_e;

   localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

   state_e           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]      r_stall;
   logic             w_load_use;

   assign w_load_use = (r_state == StRun) && ex_mem_read && (ex_regW != 5'd0) &&
                       ((id_uses_rs && (id_rs == ex_regW)) ||
                        (id_uses_rt && (id_rt == ex_regW)));

   assign div_busy     = (r_state == StDiv) && !rset;
   assign stall_cycles = r_stall;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      mem_wb_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      div_done     = 1'b0;
      if (rset) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_en    = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         w_state_nxt  = StRun;
         w_cnt_nxt    = '0;
      end else if (exc_valid) begin
         // Redirect: PC takes the vector, every in-flight instruction is squashed.
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         w_cnt_nxt    = '0;
         w_state_nxt  = inst_wait ? StDrop : StRun;
      end else if (mem_wait) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         mem_wb_flush = 1'b1;
      end else if (r_state == StDiv) begin
         if (r_cnt == '0) begin
            div_done    = 1'b1;
            w_state_nxt = StRun;
         end else begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b1;
            w_cnt_nxt    = r_cnt - 1'b1;
         end
      end else if ((r_state == StRun) && div_start) begin
         pc_en        = 1'b0;
         if_id_en     = 1'b0;
         id_ex_en     = 1'b0;
         ex_mem_en    = 1'b0;
         ex_mem_flush = 1'b1;
         w_state_nxt  = StDiv;
         w_cnt_nxt    = DivLoad;
      end else if (w_load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end else if (r_state == StDrop) begin
         // The fetch issued before the redirect is stale; bubble it when it lands.
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
         if (!inst_wait) begin
            w_state_nxt = StRun;
         end
      end else if (inst_wait) begin
         pc_en       = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rset) begin
         r_state <= StRun;
         r_cnt   <= '0;
         r_stall <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (!pc_en && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_hazard_ctrl;

   // {pc,if_id,id_ex,ex_mem,mem_wb en | if_id,id_ex,ex_mem,mem_wb flush | busy | done}
   localparam logic [10:0] CDef    = 11'b11111_0000_0_0;
   localparam logic [10:0] CRst    = 11'b00000_1111_0_0;
   localparam logic [10:0] CLu     = 11'b00111_0100_0_0;
   localparam logic [10:0] CDivSt  = 11'b00001_0010_0_0;
   localparam logic [10:0] CDivStl = 11'b00001_0010_1_0;
   localparam logic [10:0] CDivDn  = 11'b11111_0000_1_1;
   localparam logic [10:0] CMwDiv  = 11'b00001_0001_1_0;
   localparam logic [10:0] CMwRun  = 11'b00001_0001_0_0;
   localparam logic [10:0] CExcDiv = 11'b11111_1111_1_0;
   localparam logic [10:0] CExcRun = 11'b11111_1111_0_0;
   localparam logic [10:0] CIfHold = 11'b01111_1000_0_0;

   typedef struct {
      logic [10:0] ctrl;
      logic [31:0] st;
      bit          chk_st;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rset;
   logic [4:0]  id_rs, id_rt, ex_regW;
   logic        id_uses_rs, id_uses_rt, ex_mem_read, div_start, mem_wait, inst_wait, exc_valid;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, div_busy, div_done;
   logic [31:0] stall_cycles;

   exp_t        q[$];
   logic [31:0] m_stall = 32'd0;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .DIV_CYCLES(4),
      .CNT_W     (6)
   ) dut (
      .clk         (clk),
      .rset        (rset),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_regW     (ex_regW),
      .div_start   (div_start),
      .mem_wait    (mem_wait),
      .inst_wait   (inst_wait),
      .exc_valid   (exc_valid),
      .pc_en       (pc_en),
      .if_id_en    (if_id_en),
      .id_ex_en    (id_ex_en),
      .ex_mem_en   (ex_mem_en),
      .mem_wb_en   (mem_wb_en),
      .if_id_flush (if_id_flush),
      .id_ex_flush (id_ex_flush),
      .ex_mem_flush(ex_mem_flush),
      .mem_wb_flush(mem_wb_flush),
      .div_busy    (div_busy),
      .div_done    (div_done),
      .stall_cycles(stall_cycles)
   );

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; ex_regW = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      div_start = 1'b0; mem_wait = 1'b0; inst_wait = 1'b0; exc_valid = 1'b0;
   endtask

   // Inputs are already applied for this cycle; record expectation, advance one clock.
   task automatic go(input string nm, input logic [10:0] e, input bit chk = 1'b1);
      exp_t x;
      x.ctrl = e; x.st = m_stall; x.chk_st = chk; x.name = nm;
      q.push_back(x);
      if (rset) m_stall = 32'd0;
      else if (!e[10] && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [10:0] got;
      exp_t        x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x   = q.pop_front();
            got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                   ex_mem_flush, mem_wb_flush, div_busy, div_done};
            n_tests++;
            if (got !== x.ctrl) begin
               n_fail++;
               $display("FAIL %s ctrl: got %b expected %b", x.name, got, x.ctrl);
            end
            if (x.chk_st) begin
               n_tests++;
               if (stall_cycles !== x.st) begin
                  n_fail++;
                  $display("FAIL %s stall_cycles: got %h expected %h", x.name, stall_cycles, x.st);
               end
            end
         end
      end
   end

   initial begin
      idle();
      rset = 1'b1;
      @(posedge clk);
      #1;
      go("rst0", CRst, 1'b0);
      go("rst1", CRst);
      rset = 1'b0;
      go("idle", CDef);

      // Load-use via rs, then masked by $zero, then via rt.
      ex_mem_read = 1'b1; ex_regW = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      go("lu_rs", CLu);
      idle();
      go("lu_after", CDef);
      ex_mem_read = 1'b1; ex_regW = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      go("lu_r0", CDef);
      idle();
      ex_mem_read = 1'b1; ex_regW = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
      go("lu_rt", CLu);
      id_uses_rt = 1'b0;
      go("lu_nouse", CDef);
      idle();

      inst_wait = 1'b1;
      go("ifetch_wait", CIfHold);
      inst_wait = 1'b0;
      mem_wait = 1'b1;
      go("memw_run", CMwRun);
      idle();
      go("idle2", CDef);

      // Plain divide, DIV_CYCLES=4.
      div_start = 1'b1;
      go("div_start", CDivSt);
      for (int i = 0; i < 3; i++) go("div_stall", CDivStl);
      go("div_done", CDivDn);
      div_start = 1'b0;
      go("div_after", CDef);

      // Divide with a two-cycle data wait in the middle.
      div_start = 1'b1;
      go("dm_start", CDivSt);
      go("dm_stall", CDivStl);
      mem_wait = 1'b1;
      go("dm_memw", CMwDiv);
      go("dm_memw", CMwDiv);
      mem_wait = 1'b0;
      go("dm_stall", CDivStl);
      go("dm_stall", CDivStl);
      go("dm_done", CDivDn);
      div_start = 1'b0;
      go("dm_after", CDef);

      // Exception during divide with fetch outstanding.
      div_start = 1'b1;
      go("ex_start", CDivSt);
      go("ex_stall", CDivStl);
      exc_valid = 1'b1; inst_wait = 1'b1;
      go("exc_div", CExcDiv);
      exc_valid = 1'b0; div_start = 1'b0;
      for (int i = 0; i < 3; i++) go("drop_wait", CIfHold);
      inst_wait = 1'b0;
      go("drop_last", CIfHold);
      go("post_drop", CDef);
      go("post_drop2", CDef);

      // Exception outranks data wait.
      exc_valid = 1'b1; mem_wait = 1'b1;
      go("exc_memw", CExcRun);
      idle();
      go("exc_after", CDef);

      // Reset mid-divide.
      div_start = 1'b1;
      go("rd_start", CDivSt);
      go("rd_stall", CDivStl);
      rset = 1'b1;
      go("rd_rst", CRst);
      go("rd_rst", CRst);
      rset = 1'b0; div_start = 1'b0;
      go("rd_after", CDef);

      // Saturation of the stall counter.
      force dut.r_stall = 32'hFFFF_FFFE;
      #1;
      release dut.r_stall;
      m_stall = 32'hFFFF_FFFE;
      inst_wait = 1'b1;
      for (int i = 0; i < 3; i++) go("sat", CIfHold);
      inst_wait = 1'b0;
      go("sat_end", CDef);

      repeat (3) @(posedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
